pic_pc_stack_sequencer: RTL and testbench

- Parametrised instruction sequencer for the midrange core: Q1–Q4 phase counter, program counter, PCLATH, and a circular hardware return stack in one block.
- Replaces the fixed 13-bit program_counter. Adds CALL/RETURN, computed jumps, pipeline-flush signalling and stall, with PC width and stack depth generalised.
- Sits between instruction_decoder (control ops) and program_memory (fetch address and enable).

---
 rtl/pic_pc_stack_sequencer_if.sv | 32 +++
 rtl/pic_pc_stack_sequencer.sv | 149 ++++++++++++++
 tb/tb_pic_pc_stack_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pic_pc_stack_sequencer_if.sv
// Control/fetch bundle between instruction_decoder, pic_pc_stack_sequencer and program_memory.
// slave = the sequencer; master = the decoder/fetch side that drives ops and consumes pc.
interface pic_pc_stack_sequencer_if #(
    parameter int PC_WIDTH    = 13,
    parameter int STACK_DEPTH = 8,
    parameter int PTR_WIDTH   = $clog2(STACK_DEPTH)
);
    logic                  stall;
    logic [2:0]            op;
    logic [10:0]           k;
    logic [7:0]            pcl_data;
    logic                  pclath_wr_en;
    logic [PC_WIDTH-9:0]   pclath_in;
    logic [PC_WIDTH-1:0]   pc_out;
    logic [PC_WIDTH-9:0]   pclath_out;
    logic [1:0]            q_phase;
    logic                  instr_rd_en;
    logic                  flush;
    logic [PTR_WIDTH-1:0]  stack_ptr;
    logic                  stack_ovf;
    logic                  stack_unf;

    modport slave (
        input  stall, op, k, pcl_data, pclath_wr_en, pclath_in,
        output pc_out, pclath_out, q_phase, instr_rd_en, flush, stack_ptr, stack_ovf, stack_unf
    );

    modport master (
        output stall, op, k, pcl_data, pclath_wr_en, pclath_in,
        input  pc_out, pclath_out, q_phase, instr_rd_en, flush, stack_ptr, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pic_pc_stack_sequencer.sv
// Q1-Q4 phase counter, PC, PCLATH and circular return stack; all state commits on the edge ending Q4.
// Latency: pc updates once per 4-clock instruction cycle; stall freezes every register.
// Optional sticky stack fault flags are built only when PIC_STACK_FAULT_FLAGS_EN is defined.
module pic_pc_stack_sequencer #(
    parameter int PC_WIDTH    = 13,
    parameter int STACK_DEPTH = 8,
    parameter int PTR_WIDTH   = $clog2(STACK_DEPTH)
) (
    input logic                    clk,
    input logic                    rst,
    pic_pc_stack_sequencer_if.slave bus
);
    localparam int LW = PC_WIDTH - 8;

    localparam logic [2:0] OP_GOTO      = 3'd1;
    localparam logic [2:0] OP_CALL      = 3'd2;
    localparam logic [2:0] OP_RETURN    = 3'd3;
    localparam logic [2:0] OP_PCL_WRITE = 3'd4;
    localparam logic [2:0] OP_HOLD      = 3'd5;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    phase_t                phase_q, phase_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc, goto_tgt;
    logic [LW-1:0]         pclath_q, pclath_d;
    logic [PTR_WIDTH-1:0]  sp_q, sp_d, sp_dec;
    logic                  flush_q, flush_d;
    logic                  commit, push_en;
    logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];

    assign commit = (phase_q == Q4) && !bus.stall;
    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign sp_dec = sp_q - PTR_WIDTH'(1);

    // Literal covers the low 11 bits; PCLATH supplies only the bits above it.
    generate
        if (PC_WIDTH > 11) begin : g_goto_wide
            assign goto_tgt = {pclath_q[LW-1:3], bus.k};
        end else begin : g_goto_narrow
            assign goto_tgt = bus.k[PC_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) phase_q <= Q1;
        else     phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        if (!bus.stall) begin
            case (phase_q)
                Q1:      phase_d = Q2;
                Q2:      phase_d = Q3;
                Q3:      phase_d = Q4;
                default: phase_d = Q1;
            endcase
        end
    end

    // A branch landing in a flushed cycle is a NOP from the decoder, so it falls through as INCR.
    always_comb begin
        pc_d     = pc_q;
        pclath_d = pclath_q;
        sp_d     = sp_q;
        flush_d  = flush_q;
        push_en  = 1'b0;
        if (commit) begin
            pc_d    = pc_inc;
            flush_d = 1'b0;
            if (bus.pclath_wr_en) pclath_d = bus.pclath_in;
            case (bus.op)
                OP_GOTO: if (!flush_q) begin
                    pc_d    = goto_tgt;
                    flush_d = 1'b1;
                end
                OP_CALL: if (!flush_q) begin
                    pc_d    = goto_tgt;
                    sp_d    = sp_q + PTR_WIDTH'(1);
                    push_en = 1'b1;
                    flush_d = 1'b1;
                end
                OP_RETURN: if (!flush_q) begin
                    pc_d    = stack_q[sp_dec];
                    sp_d    = sp_dec;
                    flush_d = 1'b1;
                end
                OP_PCL_WRITE: if (!flush_q) begin
                    pc_d    = {pclath_q, bus.pcl_data};
                    flush_d = 1'b1;
                end
                OP_HOLD: pc_d = pc_q;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            pclath_q <= '0;
            sp_q     <= '0;
            flush_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            pclath_q <= pclath_d;
            sp_q     <= sp_d;
            flush_q  <= flush_d;
            if (push_en) stack_q[sp_q] <= pc_inc;
        end
    end

`ifdef PIC_STACK_FAULT_FLAGS_EN
    logic                 pop_en;
    logic [PTR_WIDTH:0]   live_q;
    logic                 ovf_q, unf_q;

    assign pop_en = commit && !flush_q && (bus.op == OP_RETURN);

    // Live count saturates so repeated over/underflow keeps reporting against a full/empty stack.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (push_en) begin
            if (live_q == (PTR_WIDTH+1)'(STACK_DEPTH)) ovf_q  <= 1'b1;
            else                                       live_q <= live_q + (PTR_WIDTH+1)'(1);
        end else if (pop_en) begin
            if (live_q == '0) unf_q  <= 1'b1;
            else              live_q <= live_q - (PTR_WIDTH+1)'(1);
        end
    end

    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
`else
    assign bus.stack_ovf = 1'b0;
    assign bus.stack_unf = 1'b0;
`endif

    assign bus.pc_out      = pc_q;
    assign bus.pclath_out  = pclath_q;
    assign bus.q_phase     = phase_q;
    assign bus.flush       = flush_q;
    assign bus.stack_ptr   = sp_q;
    assign bus.instr_rd_en = (phase_q == Q4) && !bus.stall && !rst;
endmodule

// File: tb/tb_pic_pc_stack_sequencer.sv
// Directed bench for pic_pc_stack_sequencer (PC_WIDTH=13, STACK_DEPTH=8); fault-flag
// expectations follow PIC_STACK_FAULT_FLAGS_EN.
module tb_pic_pc_stack_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef PIC_STACK_FAULT_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    localparam logic [2:0] INCR = 3'd0, GOTO = 3'd1, CALL = 3'd2, RET = 3'd3, PCLW = 3'd4, HOLD = 3'd5;

    pic_pc_stack_sequencer_if #(.PC_WIDTH(13), .STACK_DEPTH(8)) bus ();

    pic_pc_stack_sequencer #(.PC_WIDTH(13), .STACK_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Drives one whole instruction cycle starting from a Q1 sample point.
    task automatic instr(input logic [2:0] o, input logic [10:0] kk, input logic [7:0] pd,
                         input logic we, input logic [4:0] pin);
        bus.op = o; bus.k = kk; bus.pcl_data = pd; bus.pclath_wr_en = we; bus.pclath_in = pin;
        repeat (4) @(posedge clk);
        #1;
        bus.pclath_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.stall = 1'b0; bus.op = INCR; bus.k = '0; bus.pcl_data = '0;
        bus.pclath_wr_en = 1'b0; bus.pclath_in = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (bus.pc_out !== 13'h0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.pc_out); end
        checks++; if (bus.pclath_out !== 5'h0) begin errors++; $display("FAIL rst_pclath got %h want 0", bus.pclath_out); end
        checks++; if (bus.q_phase !== 2'd0) begin errors++; $display("FAIL rst_q got %0d want 0", bus.q_phase); end
        checks++; if (bus.flush !== 1'b0 || bus.stack_ptr !== 3'd0) begin errors++; $display("FAIL rst_flush_ptr got %b/%0d want 0/0", bus.flush, bus.stack_ptr); end
        checks++; if (bus.stack_ovf !== 1'b0 || bus.stack_unf !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", bus.stack_ovf, bus.stack_unf); end
    endtask

    task automatic test_incr();
        bus.op = INCR;
        for (int i = 0; i < 12; i++) begin
            checks++; if (bus.q_phase !== 2'(i % 4)) begin errors++; $display("FAIL incr_q[%0d] got %0d want %0d", i, bus.q_phase, i % 4); end
            checks++; if (bus.instr_rd_en !== (i % 4 == 3)) begin errors++; $display("FAIL incr_rd[%0d] got %b want %b", i, bus.instr_rd_en, i % 4 == 3); end
            checks++; if (bus.pc_out !== 13'(i / 4) || bus.flush !== 1'b0) begin errors++; $display("FAIL incr_pc[%0d] got %h/%b want %h/0", i, bus.pc_out, bus.flush, i / 4); end
            @(posedge clk); #1;
        end
        checks++; if (bus.pc_out !== 13'h3) begin errors++; $display("FAIL incr_end got %h want 3", bus.pc_out); end
    endtask

    task automatic test_goto();
        instr(INCR, 11'h0, 8'h0, 1'b1, 5'h0A);
        checks++; if (bus.pclath_out !== 5'h0A || bus.pc_out !== 13'h4) begin errors++; $display("FAIL pclath_wr got %h/%h want 0a/0004", bus.pclath_out, bus.pc_out); end
        // PCLATH rewritten in the same Q4: target still uses 0x0A, bits [4:3]=01.
        instr(GOTO, 11'h123, 8'h0, 1'b1, 5'h00);
        checks++; if (bus.pc_out !== 13'h0923) begin errors++; $display("FAIL goto_pc got %h want 0923", bus.pc_out); end
        checks++; if (bus.pclath_out !== 5'h00) begin errors++; $display("FAIL goto_pclath got %h want 00", bus.pclath_out); end
        bus.op = INCR;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL goto_flush[%0d] got %b want 1", i, bus.flush); end
            @(posedge clk); #1;
        end
        checks++; if (bus.flush !== 1'b0 || bus.pc_out !== 13'h0924) begin errors++; $display("FAIL goto_after got %b/%h want 0/0924", bus.flush, bus.pc_out); end
    endtask

    task automatic test_call_return();
        instr(PCLW, 11'h0, 8'h4F, 1'b0, 5'h0);
        instr(INCR, 11'h0, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h0050) begin errors++; $display("FAIL pclw_pc got %h want 0050", bus.pc_out); end
        instr(CALL, 11'h200, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h0200 || bus.stack_ptr !== 3'd1) begin errors++; $display("FAIL call_pc got %h/%0d want 0200/1", bus.pc_out, bus.stack_ptr); end
        instr(INCR, 11'h0, 8'h0, 1'b0, 5'h0);
        instr(RET, 11'h0, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h0051 || bus.stack_ptr !== 3'd0) begin errors++; $display("FAIL ret_pc got %h/%0d want 0051/0", bus.pc_out, bus.stack_ptr); end
        instr(INCR, 11'h0, 8'h0, 1'b0, 5'h0);
    endtask

    task automatic test_nested();
        logic [12:0] exp_pc;
        for (int i = 0; i < 9; i++) begin
            instr(CALL, 11'(11'h100 + i * 16), 8'h0, 1'b0, 5'h0);
            exp_pc = 13'(13'h100 + i * 16);
            checks++; if (bus.pc_out !== exp_pc || bus.stack_ptr !== 3'((i + 1) % 8)) begin errors++; $display("FAIL ncall_pc[%0d] got %h/%0d want %h/%0d", i, bus.pc_out, bus.stack_ptr, exp_pc, (i + 1) % 8); end
            checks++; if (bus.stack_ovf !== (FLAGS && i == 8)) begin errors++; $display("FAIL ncall_ovf[%0d] got %b want %b", i, bus.stack_ovf, FLAGS && i == 8); end
            instr(HOLD, 11'h0, 8'h0, 1'b0, 5'h0);
        end
        // Slot 0 held 0x053 but was overwritten by the 9th call's return address 0x171.
        for (int j = 1; j <= 9; j++) begin
            int s;
            s = (1 - j + 16) % 8;
            exp_pc = (s == 0) ? 13'h171 : 13'(13'h101 + (s - 1) * 16);
            instr(RET, 11'h0, 8'h0, 1'b0, 5'h0);
            checks++; if (bus.pc_out !== exp_pc || bus.stack_ptr !== 3'(s)) begin errors++; $display("FAIL nret_pc[%0d] got %h/%0d want %h/%0d", j, bus.pc_out, bus.stack_ptr, exp_pc, s); end
            checks++; if (bus.stack_unf !== (FLAGS && j == 9)) begin errors++; $display("FAIL nret_unf[%0d] got %b want %b", j, bus.stack_unf, FLAGS && j == 9); end
            instr(HOLD, 11'h0, 8'h0, 1'b0, 5'h0);
        end
    endtask

    task automatic test_stall_pclw();
        instr(INCR, 11'h0, 8'h0, 1'b1, 5'h1F);
        checks++; if (bus.pc_out !== 13'h0172) begin errors++; $display("FAIL pre_stall_pc got %h want 0172", bus.pc_out); end
        bus.op = PCLW; bus.pcl_data = 8'h7F;
        @(posedge clk); #1;
        bus.stall = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (bus.q_phase !== 2'd1 || bus.pc_out !== 13'h0172) begin errors++; $display("FAIL stall_hold got %0d/%h want 1/0172", bus.q_phase, bus.pc_out); end
        end
        bus.stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.pc_out !== 13'h1F7F || bus.flush !== 1'b1) begin errors++; $display("FAIL pclw_pc got %h/%b want 1f7f/1", bus.pc_out, bus.flush); end
        bus.op = GOTO; bus.k = 11'h7AA;
        repeat (3) @(posedge clk);
        #1;
        bus.stall = 1'b1; #1;
        checks++; if (bus.instr_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd got %b want 0", bus.instr_rd_en); end
        @(posedge clk); #1;
        checks++; if (bus.q_phase !== 2'd3 || bus.pc_out !== 13'h1F7F) begin errors++; $display("FAIL stall_q4 got %0d/%h want 3/1f7f", bus.q_phase, bus.pc_out); end
        bus.stall = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.pc_out !== 13'h1F80 || bus.flush !== 1'b0) begin errors++; $display("FAIL flushed_goto got %h/%b want 1f80/0", bus.pc_out, bus.flush); end
    endtask

    task automatic test_wrap_reset();
        instr(PCLW, 11'h0, 8'hFF, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h1FFF) begin errors++; $display("FAIL wrap_pre got %h want 1fff", bus.pc_out); end
        instr(INCR, 11'h0, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", bus.pc_out); end
        instr(CALL, 11'h005, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h1805 || bus.stack_ptr !== 3'd1) begin errors++; $display("FAIL call_hi got %h/%0d want 1805/1", bus.pc_out, bus.stack_ptr); end
        bus.op = INCR;
        repeat (3) @(posedge clk);
        #1;
        bus.stall = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.pc_out !== 13'h0 || bus.pclath_out !== 5'h0 || bus.q_phase !== 2'd0) begin errors++; $display("FAIL mid_rst got %h/%h/%0d want 0/0/0", bus.pc_out, bus.pclath_out, bus.q_phase); end
        checks++; if (bus.flush !== 1'b0 || bus.stack_ptr !== 3'd0 || bus.stack_ovf !== 1'b0 || bus.stack_unf !== 1'b0 || bus.instr_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_st got %b/%0d/%b%b/%b want 0/0/00/0", bus.flush, bus.stack_ptr, bus.stack_ovf, bus.stack_unf, bus.instr_rd_en); end
        rst = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic test_post_reset();
        // Slot 7 held 0x161 before reset; it must read back cleared.
        instr(RET, 11'h0, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h0 || bus.stack_ptr !== 3'd7) begin errors++; $display("FAIL clr_ret got %h/%0d want 0000/7", bus.pc_out, bus.stack_ptr); end
        checks++; if (bus.stack_unf !== FLAGS) begin errors++; $display("FAIL clr_unf got %b want %b", bus.stack_unf, FLAGS); end
        instr(INCR, 11'h0, 8'h0, 1'b0, 5'h0);
        instr(3'd6, 11'h0, 8'h0, 1'b0, 5'h0);
        instr(3'd7, 11'h0, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h3 || bus.flush !== 1'b0) begin errors++; $display("FAIL op67 got %h/%b want 0003/0", bus.pc_out, bus.flush); end
        instr(HOLD, 11'h0, 8'h0, 1'b0, 5'h0);
        checks++; if (bus.pc_out !== 13'h3 || bus.flush !== 1'b0) begin errors++; $display("FAIL hold got %h/%b want 0003/0", bus.pc_out, bus.flush); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_goto();
        test_call_return();
        test_nested();
        test_stall_pclw();
        test_wrap_reset();
        test_post_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
